qam16_hard_demapper: RTL and testbench
======================================

Name: qam16_hard_demapper

Overview:
- Hard-decision 16-QAM symbol demapper.
- Takes one signed 8-bit I/Q sample pair per symbol clock, slices each axis against fixed thresholds and outputs a 4-bit Gray-coded symbol.
- Sits after the receive equalizer and feeds the bit deserializer.
- Also flags valid output symbols and marks the last symbol of each fixed-length frame.

Parameters:
- THRESH, 64, outer/inner decision threshold magnitude. Nominal constellation levels are ±32 and ±96. Legal range 1..127.
- FRAME_LEN, 100, number of demapped symbols per frame. Legal range 2..65535.
- CNT_W, 16, width of the internal symbol counter. Must satisfy 2^CNT_W ≥ FRAME_LEN.

Ports:
- symbol_clock  in  1  symbol clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  when high, I_in/Q_in are sampled and demapped this cycle.
- I_in  in  8  in-phase sample, signed two's complement.
- Q_in  in  8  quadrature sample, signed two's complement.
- data_out  out  4  demapped symbol {I_bits[1:0], Q_bits[1:0]}, registered.
- available  out  1  high for one cycle per new data_out value, registered.
- complete  out  1  one-cycle pulse coincident with the available of the FRAME_LEN-th symbol.

Behaviour:
- One clock, symbol_clock. Reset is synchronous and active-high: rst sampled high at a rising edge gives data_out=0, available=0, complete=0, symbol counter=0.
- rst has priority over enable.
- Per-axis slicer (same for I and Q), signed compare, x = 8-bit sample:
  - x ≥ THRESH → 2'b10
  - 0 ≤ x < THRESH → 2'b11
  - −THRESH < x < 0 → 2'b01
  - x ≤ −THRESH → 2'b00
  - Zero slices as positive. Exactly +THRESH and −THRESH slice as outer points.
- Resulting per-axis Gray map, levels −3,−1,+1,+3 → 00,01,11,10; adjacent points differ by one bit.
- Saturating inputs −128 and +127 are ordinary outer points. The slicer must not compute abs(); compare signed values directly so −128 does not overflow.
- data_out = {slice(I_in), slice(Q_in)}.
- Latency is one clock:
  - Inputs present before edge k with enable=1 → data_out updated and available=1 after edge k.
  - No other pipeline stage.
- enable=0 at an edge:
  - data_out holds its previous value, available=0, complete=0, counter unchanged.
  - Input values are ignored.
- Symbol counter:
  - Increments on every enabled edge.
  - When an enabled edge occurs with counter == FRAME_LEN−1: complete=1 for that cycle and the counter wraps to 0.
  - Frames repeat back-to-back with no idle cycle required.
- complete is never high without available.
- Reset mid-frame discards the partial count; the next enabled symbol is symbol 1 of a new frame.
- No combinational path from inputs to outputs. All outputs come straight from flops.

Test Plan:
- Reset: rst=1 for 1 cycle with I_in=96, Q_in=96, enable=1 → after the edge data_out=0, available=0, complete=0. Deassert rst; next edge → data_out=4'hA, available=1.
- Constellation sweep, enable=1, one pair per cycle; each data_out checked one cycle later:
  - (96,96) → A
  - (32,−32) → D
  - (−32,96) → 6
  - (−96,−96) → 0
  - (96,−96) → 8
- Threshold boundaries:
  - (0,−1) → D
  - (64,−64) → 8
  - (63,−63) → D
  - (−128,127) → 2
  - (127,−128) → 8
- Enable gating: drive (96,96) → A. Then enable=0 for 3 cycles while driving (−96,−96) → data_out stays A, available=0. Re-enable → 0.
- Framing: 100 consecutive enabled symbols → complete=1 only on the 100th available cycle. Symbol 101 starts a new frame; complete next pulses on symbol 200. Insert enable=0 gaps mid-frame → pulse position still counts enabled symbols only.
- Reset mid-frame: after 40 symbols assert rst for 1 cycle → counter cleared; complete pulses on the 100th symbol after reset.

Source files
------------

// File: rtl/qam16_hard_demapper.sv
// Hard-decision 16-QAM demapper: slices signed I/Q against +/-THRESH,
// emits a Gray-coded nibble per enabled symbol and flags frame ends.
module qam16_hard_demapper #(
  parameter int THRESH    = 64,
  parameter int FRAME_LEN = 100,
  parameter int CNT_W     = 16
) (
  input  logic              symbol_clock,
  input  logic              rst,
  input  logic              enable,
  input  logic signed [7:0] I_in,
  input  logic signed [7:0] Q_in,
  output logic [3:0]        data_out,
  output logic              available,
  output logic              complete
);

  localparam logic signed [8:0] POS_T = 9'(THRESH);
  localparam logic signed [8:0] NEG_T = -9'(THRESH);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(FRAME_LEN - 1);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       i_bits;
  logic [1:0]       q_bits;

  // Widened signed compares keep -128 well-behaved without any abs().
  function automatic logic [1:0] slice(input logic signed [7:0] x);
    logic signed [8:0] xs;
    logic [1:0]        r;
    xs = 9'(x);
    r  = 2'b00;
    unique case (1'b1)
      (xs >= POS_T):                r = 2'b10;
      (xs <  POS_T && xs >= 9'sd0): r = 2'b11;
      (xs <  9'sd0 && xs > NEG_T):  r = 2'b01;
      (xs <= NEG_T):                r = 2'b00;
      default:                      r = 2'b00;
    endcase
    return r;
  endfunction

  always_comb begin
    i_bits = slice(I_in);
    q_bits = slice(Q_in);
  end

  always_ff @(posedge symbol_clock) begin
    if (rst) begin
      data_out  <= '0;
      available <= 1'b0;
      complete  <= 1'b0;
      cnt       <= '0;
    end else if (enable) begin
      data_out  <= {i_bits, q_bits};
      available <= 1'b1;
      if (cnt == LAST) begin
        complete <= 1'b1;
        cnt      <= '0;
      end else begin
        complete <= 1'b0;
        cnt      <= cnt + 1'b1;
      end
    end else begin
      available <= 1'b0;
      complete  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_qam16_hard_demapper.sv
// Vector table, random stimulus and framing checks for the
// 16-QAM hard demapper against an arithmetic reference model.
module tb_qam16_hard_demapper;

  localparam int TH = 64;
  localparam int FL = 100;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic signed [7:0] I_in;
  logic signed [7:0] Q_in;
  logic [3:0]        data_out;
  logic              available;
  logic              complete;

  int errors = 0;
  int checks = 0;

  logic [3:0] m_data;
  int         m_cnt;
  logic       m_av;
  logic       m_cp;

  qam16_hard_demapper #(
    .THRESH(TH), .FRAME_LEN(FL), .CNT_W(16)
  ) dut (
    .symbol_clock(clk),
    .rst(rst),
    .enable(enable),
    .I_in(I_in),
    .Q_in(Q_in),
    .data_out(data_out),
    .available(available),
    .complete(complete)
  );

  always #5 clk = ~clk;

  // Level index 0..3 for -3,-1,+1,+3, then binary-to-Gray.
  function automatic logic [1:0] ref_slice(input int x);
    int lvl;
    if (x >= TH) lvl = 3;
    else if (x >= 0) lvl = 2;
    else if (x > -TH) lvl = 1;
    else lvl = 0;
    return 2'(lvl ^ (lvl >> 1));
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic e,
                      input int i, input int q);
    rst = r; enable = e;
    I_in = 8'(i); Q_in = 8'(q);
    @(posedge clk);
    #1;
    if (r) begin
      m_data = 4'h0; m_cnt = 0; m_av = 1'b0; m_cp = 1'b0;
    end else if (e) begin
      m_data = {ref_slice(i), ref_slice(q)};
      m_cnt++;
      m_av = 1'b1;
      m_cp = (m_cnt == FL);
      if (m_cp) m_cnt = 0;
    end else begin
      m_av = 1'b0; m_cp = 1'b0;
    end
    check("data_out", int'(data_out), int'(m_data));
    check("available", int'(available), int'(m_av));
    check("complete", int'(complete), int'(m_cp));
  endtask

  typedef struct {
    int         i;
    int         q;
    logic [3:0] exp;
  } vec_t;

  vec_t vt[$];
  int   pulses[$];
  int   n;

  initial begin
    vt = '{
      '{96, 96, 4'hA}, '{32, -32, 4'hD}, '{-32, 96, 4'h6},
      '{-96, -96, 4'h0}, '{96, -96, 4'h8}, '{0, -1, 4'hD},
      '{64, -64, 4'h8}, '{63, -63, 4'hD}, '{-128, 127, 4'h2},
      '{127, -128, 4'h8}, '{-64, 64, 4'h2}, '{-65, -63, 4'h1}
    };

    // Reset wins over enable.
    step(1'b1, 1'b1, 96, 96);
    check("rst_data", int'(data_out), 0);
    step(1'b0, 1'b1, 96, 96);
    check("post_rst", int'(data_out), 'hA);

    foreach (vt[k]) begin
      step(1'b0, 1'b1, vt[k].i, vt[k].q);
      check($sformatf("vec%0d", k), int'(data_out), int'(vt[k].exp));
    end

    // Enable gating: output holds while inputs change.
    step(1'b0, 1'b1, 96, 96);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, -96, -96);
      check("hold", int'(data_out), 'hA);
    end
    step(1'b0, 1'b1, -96, -96);
    check("reenable", int'(data_out), 0);

    // Framing from a clean reset, back-to-back frames.
    step(1'b1, 1'b0, 0, 0);
    pulses.delete();
    for (int k = 1; k <= 2 * FL; k++) begin
      step(1'b0, 1'b1, $urandom_range(0, 255) - 128,
           $urandom_range(0, 255) - 128);
      if (complete) pulses.push_back(k);
    end
    check("frame_pulses", pulses.size(), 2);
    if (pulses.size() == 2) begin
      check("frame1_pos", pulses[0], FL);
      check("frame2_pos", pulses[1], 2 * FL);
    end

    // Gaps mid-frame: only enabled symbols count.
    step(1'b1, 1'b0, 0, 0);
    n = 0;
    pulses.delete();
    while (n < FL) begin
      logic e;
      e = ($urandom_range(0, 3) != 0);
      step(1'b0, e, $urandom_range(0, 255) - 128,
           $urandom_range(0, 255) - 128);
      if (e) n++;
      if (complete) pulses.push_back(n);
    end
    check("gap_pulses", pulses.size(), 1);
    if (pulses.size() == 1) check("gap_pos", pulses[0], FL);

    // Reset mid-frame discards the partial count.
    for (int k = 0; k < 40; k++) step(1'b0, 1'b1, 32, 32);
    step(1'b1, 1'b1, 32, 32);
    pulses.delete();
    for (int k = 1; k <= FL; k++) begin
      step(1'b0, 1'b1, -32, 96);
      if (complete) pulses.push_back(k);
    end
    check("rst_mid_pulses", pulses.size(), 1);
    if (pulses.size() == 1) check("rst_mid_pos", pulses[0], FL);

    // Random soak against the model.
    for (int k = 0; k < 1000; k++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 4) != 0,
           $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
